// File: rtl/kf8253_cond_pkg.sv
// Shared types and helpers for the KF8253 input conditioner.
package kf8253_cond_pkg;

    localparam int COND_MODE_W = 2;

    typedef enum logic [COND_MODE_W-1:0] {
        COND_DIRECT   = 2'd0,
        COND_SYNC     = 2'd1,
        COND_DIVIDED  = 2'd2,
        COND_FILTERED = 2'd3
    } cond_mode_t;

    // Widest divisor the helper handles; channels zero-extend into it.
    localparam int DIV_MAX_W = 32;

    // A divisor of zero behaves like one, giving the fastest output (period 2).
    function automatic logic [DIV_MAX_W-1:0] div_clamp(input logic [DIV_MAX_W-1:0] divisor);
        return (divisor == '0) ? DIV_MAX_W'(1) : divisor;
    endfunction

endpackage

// File: rtl/kf8253_cond_channel.sv
// One conditioned timer channel: synchroniser chains, run-length filters,
// clock divider and the channel's own mode/divisor registers.
module kf8253_cond_channel
    import kf8253_cond_pkg::*;
#(
    parameter int                   SYNC_STAGES = 2,
    parameter int                   DIV_WIDTH   = 8,
    parameter int                   FILTER_LEN  = 3,
    parameter logic [1:0]           RST_MODE    = 2'b00,
    parameter logic [DIV_WIDTH-1:0] RST_DIVISOR = DIV_WIDTH'(1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_mode,
    input  logic [DIV_WIDTH-1:0] cfg_divisor,
    input  logic                 ext_clock,
    input  logic                 ext_gate,
    output logic                 counter_clock,
    output logic                 counter_gate,
    output logic [1:0]           mode
);

    localparam int             RUN_W    = $clog2(FILTER_LEN);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

    cond_mode_t             mode_q, mode_d;
    logic [DIV_WIDTH-1:0]   divisor_q, divisor_d;
    logic                   chg_q, chg_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] gate_sync_q, gate_sync_d;
    logic [RUN_W-1:0]       clk_run_q, clk_run_d;
    logic [RUN_W-1:0]       gate_run_q, gate_run_d;
    logic                   clk_filt_q, clk_filt_d;
    logic                   gate_filt_q, gate_filt_d;
    logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
    logic                   div_clk_q, div_clk_d;
    logic [DIV_WIDTH-1:0]   div_last;
    logic                   clk_sel;
    logic                   gate_sel;

    // The filter looks at the sample entering the last synchroniser stage so
    // the total latency is SYNC_STAGES + FILTER_LEN - 1 edges.
    function automatic logic [RUN_W:0] filter_step(input logic             sample,
                                                   input logic             filt,
                                                   input logic [RUN_W-1:0] run);
        logic [RUN_W:0] res;
        if (sample == filt) begin
            res = {filt, RUN_W'(0)};
        end else if (run == RUN_LAST) begin
            res = {sample, RUN_W'(0)};
        end else begin
            res = {filt, run + RUN_W'(1)};
        end
        return res;
    endfunction

    assign div_last = DIV_WIDTH'(div_clamp(DIV_MAX_W'(divisor_q)) - DIV_MAX_W'(1));
    assign mode     = mode_q;

    // Next-state logic; a configuration write overrides the divider terminal count.
    always_comb begin
        mode_d      = mode_q;
        divisor_d   = divisor_q;
        chg_d       = 1'b0;
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ext_clock};
        gate_sync_d = {gate_sync_q[SYNC_STAGES-2:0], ext_gate};
        {clk_filt_d, clk_run_d}   = filter_step(clk_sync_q[SYNC_STAGES-2], clk_filt_q, clk_run_q);
        {gate_filt_d, gate_run_d} = filter_step(gate_sync_q[SYNC_STAGES-2], gate_filt_q, gate_run_q);
        div_cnt_d   = div_cnt_q;
        div_clk_d   = div_clk_q;

        if (mode_q == COND_DIVIDED) begin
            if (div_cnt_q >= div_last) begin
                div_cnt_d = '0;
                div_clk_d = ~div_clk_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
            end
        end

        if (cfg_we) begin
            divisor_d = cfg_divisor;
            div_cnt_d = '0;
            div_clk_d = div_clk_q;
            if (cfg_mode != mode_q) begin
                mode_d      = cond_mode_t'(cfg_mode);
                chg_d       = 1'b1;
                clk_sync_d  = '0;
                gate_sync_d = '0;
                clk_filt_d  = 1'b0;
                clk_run_d   = '0;
                gate_filt_d = 1'b0;
                gate_run_d  = '0;
                div_clk_d   = 1'b0;
            end
        end
    end

    // Channel state, cleared by the synchronised core reset.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            mode_q      <= cond_mode_t'(RST_MODE);
            divisor_q   <= RST_DIVISOR;
            chg_q       <= 1'b0;
            clk_sync_q  <= '0;
            gate_sync_q <= '0;
            clk_run_q   <= '0;
            gate_run_q  <= '0;
            clk_filt_q  <= 1'b0;
            gate_filt_q <= 1'b0;
            div_cnt_q   <= '0;
            div_clk_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            divisor_q   <= divisor_d;
            chg_q       <= chg_d;
            clk_sync_q  <= clk_sync_d;
            gate_sync_q <= gate_sync_d;
            clk_run_q   <= clk_run_d;
            gate_run_q  <= gate_run_d;
            clk_filt_q  <= clk_filt_d;
            gate_filt_q <= gate_filt_d;
            div_cnt_q   <= div_cnt_d;
            div_clk_q   <= div_clk_d;
        end
    end

    // Output select; the clock is held low for the edge following a mode change.
    always_comb begin
        clk_sel  = 1'b0;
        gate_sel = 1'b0;
        case (mode_q)
            COND_DIRECT: begin
                clk_sel  = ext_clock;
                gate_sel = ext_gate;
            end
            COND_SYNC: begin
                clk_sel  = clk_sync_q[SYNC_STAGES-1];
                gate_sel = gate_sync_q[SYNC_STAGES-1];
            end
            COND_DIVIDED: begin
                clk_sel  = div_clk_q;
                gate_sel = ext_gate;
            end
            default: begin
                clk_sel  = clk_filt_q;
                gate_sel = gate_filt_q;
            end
        endcase
        counter_clock = clk_sel & ~reset & ~chg_q;
        counter_gate  = gate_sel & ~reset;
    end

endmodule

// File: rtl/kf8253_input_conditioner.sv
// KF8253 input conditioner: reset synchroniser, configuration decode and
// one conditioning channel per counter.
module kf8253_input_conditioner
    import kf8253_cond_pkg::*;
#(
    parameter int                  CHANNELS      = 3,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  DIV_WIDTH     = 8,
    parameter int                  FILTER_LEN    = 3,
    parameter logic [2*CHANNELS-1:0] RESET_MODE  = 6'b10_01_00,
    parameter int                  RESET_DIVISOR = 1,
    localparam int                 CH_IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clock,
    input  logic                  reset_in,
    output logic                  reset,
    input  logic                  cfg_write,
    input  logic [CH_IDX_W-1:0]   cfg_channel,
    input  logic [1:0]            cfg_mode,
    input  logic [DIV_WIDTH-1:0]  cfg_divisor,
    input  logic [CHANNELS-1:0]   ext_clock,
    input  logic [CHANNELS-1:0]   ext_gate,
    output logic [CHANNELS-1:0]   counter_clock,
    output logic [CHANNELS-1:0]   counter_gate,
    output logic [2*CHANNELS-1:0] channel_mode
);

    logic                rst_meta_q, rst_meta_d;
    logic                rst_sync_q, rst_sync_d;
    logic [CHANNELS-1:0] cfg_we;

    // Reset release shifts a zero through two stages.
    always_comb begin
        rst_meta_d = 1'b0;
        rst_sync_d = rst_meta_q;
    end

    // Reset asserts immediately with reset_in and releases on the falling edge.
    always_ff @(negedge clock or posedge reset_in) begin
        if (reset_in) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    assign reset = rst_sync_q;

    // Route the write strobe to one channel; out-of-range indices match none.
    always_comb begin
        cfg_we = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cfg_we[i] = cfg_write && (cfg_channel == CH_IDX_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        kf8253_cond_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DIV_WIDTH   (DIV_WIDTH),
            .FILTER_LEN  (FILTER_LEN),
            .RST_MODE    (RESET_MODE[2*g +: 2]),
            .RST_DIVISOR (DIV_WIDTH'(RESET_DIVISOR))
        ) u_chan (
            .clock         (clock),
            .reset         (rst_sync_q),
            .cfg_we        (cfg_we[g]),
            .cfg_mode      (cfg_mode),
            .cfg_divisor   (cfg_divisor),
            .ext_clock     (ext_clock[g]),
            .ext_gate      (ext_gate[g]),
            .counter_clock (counter_clock[g]),
            .counter_gate  (counter_gate[g]),
            .mode          (channel_mode[2*g +: 2])
        );
    end

endmodule
